// File: rtl/link_fsm_pkg.sv
// Shared state encodings and default parameters for the link-control FSM.
// Optional idle hysteresis is selected with LINK_FSM_IDLE_HOLD_EN.
package link_fsm_pkg;

   localparam int unsigned N_CH_DEF      = 8;
   localparam int unsigned TH_W_DEF      = 8;
   localparam int unsigned IDLE_HOLD_DEF = 4;
   localparam int unsigned ST_W          = 3;

   typedef enum logic [ST_W-1:0] {
      ST_RESET  = 3'b000,
      ST_INIT   = 3'b001,
      ST_IDLE   = 3'b010,
      ST_ACTIVE = 3'b100,
      ST_ERROR  = 3'b101
   } link_state_e;

   // Bits needed to hold a count from 0 up to and including max_val.
   function automatic int unsigned cnt_width(input int unsigned max_val);
      return (max_val < 2) ? 1 : $clog2(max_val + 1);
   endfunction

endpackage

// File: rtl/link_ctrl_fsm_if.sv
// Link-control bundle between the FSM (slave) and its environment (master).
interface link_ctrl_fsm_if
   import link_fsm_pkg::*;
#(
   parameter int unsigned N_CH = N_CH_DEF,
   parameter int unsigned TH_W = TH_W_DEF
);
   logic                 init;
   logic [TH_W-1:0]      umbral_lo;
   logic [TH_W-1:0]      umbral_hi;
   logic [N_CH-1:0]      empty_fifo;
   logic [N_CH-1:0]      error_fifo;
   logic [ST_W-1:0]      state;
   logic [ST_W-1:0]      nxt_state;
   logic [TH_W-1:0]      umbral_lo_out;
   logic [TH_W-1:0]      umbral_hi_out;
   logic                 idle_out;
   logic                 active_out;
   logic                 error_out;
   logic                 cfg_err;
   logic [N_CH-1:0]      err_ch;

   modport master (
      output init, umbral_lo, umbral_hi, empty_fifo, error_fifo,
      input  state, nxt_state, umbral_lo_out, umbral_hi_out,
             idle_out, active_out, error_out, cfg_err, err_ch
   );

   modport slave (
      input  init, umbral_lo, umbral_hi, empty_fifo, error_fifo,
      output state, nxt_state, umbral_lo_out, umbral_hi_out,
             idle_out, active_out, error_out, cfg_err, err_ch
   );
endinterface

// File: rtl/link_ctrl_fsm_idle_hold.sv
// Saturating hold counter; done_c flags the cycle that completes MAX
// consecutive enabled cycles.
module idle_hold_cnt
   import link_fsm_pkg::*;
#(
   parameter int unsigned MAX = IDLE_HOLD_DEF
) (
   input  logic clk,
   input  logic reset,
   input  logic clr,
   input  logic en,
   output logic done_c
);
   localparam int unsigned CW   = cnt_width(MAX);
   localparam logic [CW-1:0] LAST = CW'(MAX - 1);
   localparam logic [CW-1:0] TOP  = CW'(MAX);

   logic [CW-1:0] cnt_q;

   always_ff @(posedge clk or posedge reset) begin
      if (reset)                      cnt_q <= '0;
      else if (clr)                   cnt_q <= '0;
      else if (en && (cnt_q != TOP))  cnt_q <= cnt_q + CW'(1);
   end

   assign done_c = en && (cnt_q >= LAST);

endmodule

// File: rtl/link_ctrl_fsm.sv
// Link-control FSM: RESET/INIT/IDLE/ACTIVE/ERROR sequencing, threshold capture
// and sticky per-channel error record. LINK_FSM_IDLE_HOLD_EN adds idle hysteresis.
module link_ctrl_fsm
   import link_fsm_pkg::*;
#(
   parameter int unsigned N_CH      = N_CH_DEF,
   parameter int unsigned TH_W      = TH_W_DEF,
   parameter int unsigned IDLE_HOLD = IDLE_HOLD_DEF
) (
   input  logic            clk,
   input  logic            reset,
   link_ctrl_fsm_if.slave  bus
);

   if ((N_CH < 1) || (N_CH > 32) || (IDLE_HOLD < 1)) begin : g_bad_cfg
      $error("link_ctrl_fsm: N_CH must be 1..32 and IDLE_HOLD >= 1");
   end

   link_state_e     state_q;
   link_state_e     state_d;
   logic            any_err_c;
   logic            all_empty_c;
   logic            th_ok_c;
   logic            hold_done_c;
   logic [TH_W-1:0] lo_q;
   logic [TH_W-1:0] hi_q;
   logic            cfg_err_q;
   logic            idle_q;
   logic            active_q;
   logic            error_q;
   logic [N_CH-1:0] err_ch_q;

   assign any_err_c   = |bus.error_fifo;
   assign all_empty_c = &bus.empty_fifo;
   assign th_ok_c     = (bus.umbral_lo <= bus.umbral_hi);

`ifdef LINK_FSM_IDLE_HOLD_EN
   logic hold_en_c;
   logic hold_clr_c;

   // Counts all-empty cycles in ACTIVE; anything else restarts the window.
   assign hold_en_c  = (state_q == ST_ACTIVE) && all_empty_c;
   assign hold_clr_c = !hold_en_c;

   idle_hold_cnt #(
      .MAX (IDLE_HOLD)
   ) u_idle_hold (
      .clk    (clk),
      .reset  (reset),
      .clr    (hold_clr_c),
      .en     (hold_en_c),
      .done_c (hold_done_c)
   );
`else
   assign hold_done_c = 1'b1;
`endif

   always_ff @(posedge clk or posedge reset) begin
      if (reset) state_q <= ST_RESET;
      else       state_q <= state_d;
   end

   // Next-state: errors dominate, reconfiguration is only honoured from IDLE.
   always_comb begin
      state_d = ST_RESET;
      case (state_q)
         ST_RESET:  state_d = ST_INIT;
         ST_INIT:   state_d = (bus.init && th_ok_c) ? ST_IDLE : ST_INIT;
         ST_IDLE: begin
            if (any_err_c)         state_d = ST_ERROR;
            else if (!bus.init)    state_d = ST_INIT;
            else if (!all_empty_c) state_d = ST_ACTIVE;
            else                   state_d = ST_IDLE;
         end
         ST_ACTIVE: begin
            if (any_err_c)                       state_d = ST_ERROR;
            else if (all_empty_c && hold_done_c) state_d = ST_IDLE;
            else                                 state_d = ST_ACTIVE;
         end
         ST_ERROR:  state_d = bus.init ? ST_INIT : ST_ERROR;
         default:   state_d = ST_RESET;
      endcase
   end

   // Status flags are taken from the next state so they line up with state_q.
   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         idle_q   <= 1'b0;
         active_q <= 1'b0;
         error_q  <= 1'b0;
      end else begin
         idle_q   <= (state_d == ST_IDLE);
         active_q <= (state_d == ST_ACTIVE);
         error_q  <= (state_d == ST_ERROR);
      end
   end

   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         lo_q      <= '0;
         hi_q      <= '0;
         cfg_err_q <= 1'b0;
      end else if (state_q == ST_INIT) begin
         lo_q      <= bus.umbral_lo;
         hi_q      <= bus.umbral_hi;
         cfg_err_q <= !th_ok_c;
      end
   end

   // Sticky error record; accumulating in IDLE/ACTIVE also covers the ERROR entry edge.
   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         err_ch_q <= '0;
      end else begin
         case (state_q)
            ST_IDLE,
            ST_ACTIVE: err_ch_q <= err_ch_q | bus.error_fifo;
            ST_ERROR:  if (bus.init) err_ch_q <= '0;
            default:   err_ch_q <= err_ch_q;
         endcase
      end
   end

   assign bus.state         = state_q;
   assign bus.nxt_state     = state_d;
   assign bus.umbral_lo_out = lo_q;
   assign bus.umbral_hi_out = hi_q;
   assign bus.cfg_err       = cfg_err_q;
   assign bus.idle_out      = idle_q;
   assign bus.active_out    = active_q;
   assign bus.error_out     = error_q;
   assign bus.err_ch        = err_ch_q;

endmodule

// File: tb/tb_link_ctrl_fsm.sv
// Directed bench for link_ctrl_fsm (N_CH=8 main instance, N_CH=4/16 for async reset).
// Expectations follow LINK_FSM_IDLE_HOLD_EN when defined.
module tb_link_ctrl_fsm;
   import link_fsm_pkg::*;

   localparam int unsigned HOLD = 4;
`ifdef LINK_FSM_IDLE_HOLD_EN
   localparam int unsigned DRAIN = HOLD;
`else
   localparam int unsigned DRAIN = 1;
`endif

   logic clk = 1'b0;
   logic reset;
   int   checks = 0;
   int   errors = 0;

   always #5 clk = ~clk;

   link_ctrl_fsm_if #(.N_CH(8),  .TH_W(8)) bus8  ();
   link_ctrl_fsm_if #(.N_CH(4),  .TH_W(8)) bus4  ();
   link_ctrl_fsm_if #(.N_CH(16), .TH_W(8)) bus16 ();

   link_ctrl_fsm #(.N_CH(8),  .TH_W(8), .IDLE_HOLD(HOLD)) dut8  (.clk(clk), .reset(reset), .bus(bus8));
   link_ctrl_fsm #(.N_CH(4),  .TH_W(8), .IDLE_HOLD(HOLD)) dut4  (.clk(clk), .reset(reset), .bus(bus4));
   link_ctrl_fsm #(.N_CH(16), .TH_W(8), .IDLE_HOLD(HOLD)) dut16 (.clk(clk), .reset(reset), .bus(bus16));

   // Expected {state, idle, active, error} for a given state encoding.
   function automatic logic [5:0] exp_st(input logic [2:0] s);
      return {s, s == 3'b010, s == 3'b100, s == 3'b101};
   endfunction

   function automatic logic [5:0] obs8();
      return {bus8.state, bus8.idle_out, bus8.active_out, bus8.error_out};
   endfunction

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   task automatic test_reset();
      reset = 1'b1;
      bus8.init = 1'b0;  bus8.umbral_lo = 8'h00;  bus8.umbral_hi = 8'h00;
      bus8.empty_fifo = 8'hFF;  bus8.error_fifo = 8'h00;
      bus4.init = 1'b0;  bus4.umbral_lo = 8'h00;  bus4.umbral_hi = 8'h00;
      bus4.empty_fifo = 4'hF;  bus4.error_fifo = 4'h0;
      bus16.init = 1'b0; bus16.umbral_lo = 8'h00; bus16.umbral_hi = 8'h00;
      bus16.empty_fifo = 16'hFFFF; bus16.error_fifo = 16'h0000;
      tick(); tick();
      checks++;
      if (obs8() !== exp_st(3'b000)) begin
         errors++; $display("FAIL reset_status got %b exp %b", obs8(), exp_st(3'b000));
      end
      checks++;
      if ({bus8.umbral_lo_out, bus8.umbral_hi_out, bus8.cfg_err, bus8.err_ch} !== 25'd0) begin
         errors++; $display("FAIL reset_regs got lo=%h hi=%h cfg=%b err=%h exp all 0",
                             bus8.umbral_lo_out, bus8.umbral_hi_out, bus8.cfg_err, bus8.err_ch);
      end
      checks++;
      if (bus8.nxt_state !== 3'b001) begin
         errors++; $display("FAIL reset_nxt got %b exp 001", bus8.nxt_state);
      end
      #2;
      bus8.init = 1'b1; bus8.umbral_lo = 8'h10; bus8.umbral_hi = 8'h30;
      reset = 1'b0;
      tick();
      checks++;
      if (obs8() !== exp_st(3'b001)) begin
         errors++; $display("FAIL first_init got %b exp %b", obs8(), exp_st(3'b001));
      end
      tick();
      checks++;
      if (obs8() !== exp_st(3'b010)) begin
         errors++; $display("FAIL first_idle got %b exp %b", obs8(), exp_st(3'b010));
      end
      checks++;
      if ({bus8.umbral_lo_out, bus8.umbral_hi_out, bus8.cfg_err} !== {8'h10, 8'h30, 1'b0}) begin
         errors++; $display("FAIL first_thresh got %h/%h cfg=%b exp 10/30 cfg=0",
                             bus8.umbral_lo_out, bus8.umbral_hi_out, bus8.cfg_err);
      end
   endtask

   task automatic test_cfg_err();
      bus8.init = 1'b0;
      tick();
      checks++;
      if (obs8() !== exp_st(3'b001)) begin
         errors++; $display("FAIL reconf_init got %b exp %b", obs8(), exp_st(3'b001));
      end
      bus8.umbral_lo = 8'h40; bus8.umbral_hi = 8'h20; bus8.init = 1'b1;
      tick(); tick();
      checks++;
      if (obs8() !== exp_st(3'b001)) begin
         errors++; $display("FAIL bad_cfg_state got %b exp %b", obs8(), exp_st(3'b001));
      end
      checks++;
      if ({bus8.cfg_err, bus8.umbral_lo_out} !== {1'b1, 8'h40}) begin
         errors++; $display("FAIL bad_cfg_flag got cfg=%b lo=%h exp cfg=1 lo=40",
                             bus8.cfg_err, bus8.umbral_lo_out);
      end
      bus8.umbral_lo = 8'h20;
      tick();
      checks++;
      if (obs8() !== exp_st(3'b010)) begin
         errors++; $display("FAIL fixed_cfg_state got %b exp %b", obs8(), exp_st(3'b010));
      end
      checks++;
      if ({bus8.cfg_err, bus8.umbral_lo_out, bus8.umbral_hi_out} !== {1'b0, 8'h20, 8'h20}) begin
         errors++; $display("FAIL fixed_cfg_flag got cfg=%b lo=%h hi=%h exp cfg=0 lo=20 hi=20",
                             bus8.cfg_err, bus8.umbral_lo_out, bus8.umbral_hi_out);
      end
   endtask

   task automatic test_active_idle();
      bus8.empty_fifo = 8'hFE;
      tick();
      checks++;
      if (obs8() !== exp_st(3'b100)) begin
         errors++; $display("FAIL go_active got %b exp %b", obs8(), exp_st(3'b100));
      end
      bus8.empty_fifo = 8'hFF;
`ifdef LINK_FSM_IDLE_HOLD_EN
      for (int i = 0; i < int'(HOLD) - 1; i++) begin
         tick();
         checks++;
         if (obs8() !== exp_st(3'b100)) begin
            errors++; $display("FAIL hold_pre%0d got %b exp %b", i, obs8(), exp_st(3'b100));
         end
      end
      bus8.empty_fifo = 8'hEF;
      tick();
      checks++;
      if (obs8() !== exp_st(3'b100)) begin
         errors++; $display("FAIL hold_restart got %b exp %b", obs8(), exp_st(3'b100));
      end
      bus8.empty_fifo = 8'hFF;
`endif
      for (int i = 0; i < int'(DRAIN) - 1; i++) begin
         tick();
         checks++;
         if (obs8() !== exp_st(3'b100)) begin
            errors++; $display("FAIL hold_wait%0d got %b exp %b", i, obs8(), exp_st(3'b100));
         end
      end
      tick();
      checks++;
      if (obs8() !== exp_st(3'b010)) begin
         errors++; $display("FAIL back_idle got %b exp %b", obs8(), exp_st(3'b010));
      end
   endtask

   task automatic test_error();
      bus8.empty_fifo = 8'h00;
      tick();
      bus8.init = 1'b0;
      tick();
      checks++;
      if (obs8() !== exp_st(3'b100)) begin
         errors++; $display("FAIL active_ignores_init got %b exp %b", obs8(), exp_st(3'b100));
      end
      bus8.error_fifo = 8'h24;
      tick();
      bus8.error_fifo = 8'h00;
      checks++;
      if ({obs8(), bus8.err_ch} !== {exp_st(3'b101), 8'h24}) begin
         errors++; $display("FAIL err_entry got st=%b err_ch=%h exp st=%b err_ch=24",
                             obs8(), bus8.err_ch, exp_st(3'b101));
      end
      tick(); tick();
      checks++;
      if ({obs8(), bus8.err_ch} !== {exp_st(3'b101), 8'h24}) begin
         errors++; $display("FAIL err_hold got st=%b err_ch=%h exp st=%b err_ch=24",
                             obs8(), bus8.err_ch, exp_st(3'b101));
      end
      bus8.init = 1'b1; bus8.empty_fifo = 8'hFF;
      tick();
      checks++;
      if ({obs8(), bus8.err_ch} !== {exp_st(3'b001), 8'h00}) begin
         errors++; $display("FAIL err_clear got st=%b err_ch=%h exp st=%b err_ch=00",
                             obs8(), bus8.err_ch, exp_st(3'b001));
      end
      tick();
      checks++;
      if (obs8() !== exp_st(3'b010)) begin
         errors++; $display("FAIL err_reidle got %b exp %b", obs8(), exp_st(3'b010));
      end
   endtask

   task automatic test_priority();
      bus8.init = 1'b0; bus8.empty_fifo = 8'h7F;
      tick();
      checks++;
      if (obs8() !== exp_st(3'b001)) begin
         errors++; $display("FAIL init_wins got %b exp %b", obs8(), exp_st(3'b001));
      end
      bus8.init = 1'b1; bus8.empty_fifo = 8'hFF;
      tick();
      bus8.error_fifo = 8'h01; bus8.empty_fifo = 8'h7F;
      tick();
      bus8.error_fifo = 8'h00; bus8.empty_fifo = 8'hFF;
      checks++;
      if ({obs8(), bus8.err_ch} !== {exp_st(3'b101), 8'h01}) begin
         errors++; $display("FAIL error_wins got st=%b err_ch=%h exp st=%b err_ch=01",
                             obs8(), bus8.err_ch, exp_st(3'b101));
      end
      tick(); tick();
      checks++;
      if ({obs8(), bus8.err_ch} !== {exp_st(3'b010), 8'h00}) begin
         errors++; $display("FAIL prio_recover got st=%b err_ch=%h exp st=%b err_ch=00",
                             obs8(), bus8.err_ch, exp_st(3'b010));
      end
   endtask

   task automatic test_drain();
      bus8.empty_fifo = 8'h00;
      tick();
      bus8.init = 1'b0;
      tick();
      bus8.empty_fifo = 8'hFF;
      for (int i = 0; i < int'(DRAIN) - 1; i++) begin
         tick();
         checks++;
         if (obs8() !== exp_st(3'b100)) begin
            errors++; $display("FAIL drain_wait%0d got %b exp %b", i, obs8(), exp_st(3'b100));
         end
      end
      tick();
      checks++;
      if (obs8() !== exp_st(3'b010)) begin
         errors++; $display("FAIL drain_idle got %b exp %b", obs8(), exp_st(3'b010));
      end
      tick();
      checks++;
      if (obs8() !== exp_st(3'b001)) begin
         errors++; $display("FAIL drain_init got %b exp %b", obs8(), exp_st(3'b001));
      end
   endtask

   task automatic test_async_reset();
      bus8.init = 1'b1;
      bus4.init = 1'b1;  bus4.umbral_lo = 8'h03;  bus4.umbral_hi = 8'h05;
      bus16.init = 1'b1; bus16.umbral_lo = 8'h03; bus16.umbral_hi = 8'h05;
      tick();
      checks++;
      if ({bus4.state, bus16.state} !== {3'b010, 3'b010}) begin
         errors++; $display("FAIL var_idle got n4=%b n16=%b exp 010", bus4.state, bus16.state);
      end
      bus8.empty_fifo = 8'h00; bus4.empty_fifo = 4'h0; bus16.empty_fifo = 16'h0000;
      bus16.error_fifo = 16'h0000;
      tick();
      checks++;
      if ({obs8(), bus4.state, bus4.active_out, bus16.state, bus16.active_out}
          !== {exp_st(3'b100), 3'b100, 1'b1, 3'b100, 1'b1}) begin
         errors++; $display("FAIL pre_reset_active got n8=%b n4=%b n16=%b exp all active",
                             obs8(), bus4.state, bus16.state);
      end
      #3;
      reset = 1'b1;
      #1;
      checks++;
      if ({obs8(), bus8.umbral_lo_out, bus8.umbral_hi_out, bus8.cfg_err, bus8.err_ch} !== 31'd0) begin
         errors++; $display("FAIL async_n8 got st=%b lo=%h hi=%h err=%h exp all 0",
                             obs8(), bus8.umbral_lo_out, bus8.umbral_hi_out, bus8.err_ch);
      end
      checks++;
      if ({bus4.state, bus4.idle_out, bus4.active_out, bus4.error_out, bus4.umbral_lo_out,
           bus4.umbral_hi_out, bus4.cfg_err, bus4.err_ch} !== 27'd0) begin
         errors++; $display("FAIL async_n4 got st=%b lo=%h hi=%h err=%h exp all 0",
                             bus4.state, bus4.umbral_lo_out, bus4.umbral_hi_out, bus4.err_ch);
      end
      checks++;
      if ({bus16.state, bus16.idle_out, bus16.active_out, bus16.error_out, bus16.umbral_lo_out,
           bus16.umbral_hi_out, bus16.cfg_err, bus16.err_ch} !== 39'd0) begin
         errors++; $display("FAIL async_n16 got st=%b lo=%h hi=%h err=%h exp all 0",
                             bus16.state, bus16.umbral_lo_out, bus16.umbral_hi_out, bus16.err_ch);
      end
      #2;
      reset = 1'b0;
      tick();
      checks++;
      if (obs8() !== exp_st(3'b001)) begin
         errors++; $display("FAIL post_reset_init got %b exp %b", obs8(), exp_st(3'b001));
      end
   endtask

   initial begin
      test_reset();
      test_cfg_err();
      test_active_idle();
      test_error();
      test_priority();
      test_drain();
      test_async_reset();
      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end

endmodule
